// File: rtl/pl_nn_accel.sv
// Purpose : single-perceptron engine: ReLU/saturate(dot(image, weight) + bias), loaded over AXI4-Lite
// Latency : a_0_tvalid rises 787 cycles after the accepted start edge; AXI read data 2 cycles after AR
// Backpres: result held on a_0_tdata until a_0_tready; one AXI write and one AXI read in flight at a time
// Ports   : ACLK_0/ARESETN_0 clock and async active-low reset; S00_AXI_0_* AXI4-Lite slave
//           (image 0x0000, weight 0x1000, bias 0x3000, status 0x3004, result 0x3008);
//           start_0/adone run request and downstream-idle enable; a_0_t* result stream master.
module pl_nn_accel #(
  parameter int N_INPUTS = 784,
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 32
) (
  input  logic                  ACLK_0,
  input  logic                  ARESETN_0,
  input  logic [ADDR_W-1:0]     S00_AXI_0_awaddr,
  input  logic [2:0]            S00_AXI_0_awprot,
  input  logic                  S00_AXI_0_awvalid,
  output logic                  S00_AXI_0_awready,
  input  logic [DATA_W-1:0]     S00_AXI_0_wdata,
  input  logic [DATA_W/8-1:0]   S00_AXI_0_wstrb,
  input  logic                  S00_AXI_0_wvalid,
  output logic                  S00_AXI_0_wready,
  output logic [1:0]            S00_AXI_0_bresp,
  output logic                  S00_AXI_0_bvalid,
  input  logic                  S00_AXI_0_bready,
  input  logic [ADDR_W-1:0]     S00_AXI_0_araddr,
  input  logic [2:0]            S00_AXI_0_arprot,
  input  logic                  S00_AXI_0_arvalid,
  output logic                  S00_AXI_0_arready,
  output logic [DATA_W-1:0]     S00_AXI_0_rdata,
  output logic [1:0]            S00_AXI_0_rresp,
  output logic                  S00_AXI_0_rvalid,
  input  logic                  S00_AXI_0_rready,
  input  logic                  start_0,
  input  logic                  adone,
  output logic [DATA_W-1:0]     a_0_tdata,
  output logic                  a_0_tvalid,
  input  logic                  a_0_tready
);

  localparam int IDX_W = $clog2(N_INPUTS);
  localparam int WRD_W = ADDR_W - 2;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_INPUTS - 1);
  localparam logic [WRD_W-1:0] W_BIAS   = WRD_W'('h3000 >> 2);
  localparam logic [WRD_W-1:0] W_STAT   = WRD_W'('h3004 >> 2);
  localparam logic [WRD_W-1:0] W_RES    = WRD_W'('h3008 >> 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RUN    = 3'd1;
  localparam logic [2:0] S_DRAIN  = 3'd2;
  localparam logic [2:0] S_FINISH = 3'd3;
  localparam logic [2:0] S_OUT    = 3'd4;

  logic unused_bits;
  assign unused_bits = ^{S00_AXI_0_awprot, S00_AXI_0_arprot,
                         S00_AXI_0_awaddr[1:0], S00_AXI_0_araddr[1:0]};

  logic [DATA_W-1:0] img_mem [N_INPUTS];
  logic [DATA_W-1:0] wt_mem  [N_INPUTS];

  logic                aw_rdy, ar_rdy, rd_s1, rd_s2;
  logic [WRD_W-1:0]    rd_word;
  logic [DATA_W-1:0]   ax_img_q, ax_wt_q, rd_mux;
  logic [DATA_W-1:0]   bias, result;
  logic [2:0]          state;
  logic [IDX_W-1:0]    idx;
  logic                busy, result_valid, start_q, rd_vld, mul_vld;
  logic [DATA_W-1:0]   eng_img, eng_wt;
  logic signed [2*DATA_W-1:0] prod, acc, sum, img_x, wt_x;
  logic [DATA_W-1:0]   sat;

  // Write decode: region in the top two word-address bits, RAM index below.
  logic [WRD_W-1:0] wr_word;
  logic             wr_img, wr_wt;
  assign wr_word = S00_AXI_0_awaddr[ADDR_W-1:2];
  assign wr_img  = (wr_word[WRD_W-1 -: 2] == 2'd0) && (wr_word[IDX_W-1:0] <= IDX_LAST);
  assign wr_wt   = (wr_word[WRD_W-1 -: 2] == 2'd1) && (wr_word[IDX_W-1:0] <= IDX_LAST);

  assign S00_AXI_0_awready = aw_rdy;
  assign S00_AXI_0_wready  = aw_rdy;
  assign S00_AXI_0_arready = ar_rdy;
  assign S00_AXI_0_bresp   = 2'b00;
  assign S00_AXI_0_rresp   = 2'b00;

  wire start_edge = start_0 && !start_q;

  // RAMs: one write port (AXI) and two registered read ports (AXI, engine).
  always_ff @(posedge ACLK_0) begin
    for (int b = 0; b < DATA_W/8; b++) begin
      if (aw_rdy && wr_img && S00_AXI_0_wstrb[b])
        img_mem[wr_word[IDX_W-1:0]][8*b +: 8] <= S00_AXI_0_wdata[8*b +: 8];
      if (aw_rdy && wr_wt && S00_AXI_0_wstrb[b])
        wt_mem[wr_word[IDX_W-1:0]][8*b +: 8] <= S00_AXI_0_wdata[8*b +: 8];
    end
    eng_img  <= img_mem[idx];
    eng_wt   <= wt_mem[idx];
    ax_img_q <= img_mem[rd_word[IDX_W-1:0]];
    ax_wt_q  <= wt_mem[rd_word[IDX_W-1:0]];
  end

  always_comb begin
    rd_mux = '0;
    if (rd_word[IDX_W-1:0] <= IDX_LAST && rd_word[WRD_W-1 -: 2] == 2'd0) rd_mux = ax_img_q;
    if (rd_word[IDX_W-1:0] <= IDX_LAST && rd_word[WRD_W-1 -: 2] == 2'd1) rd_mux = ax_wt_q;
    if (rd_word == W_BIAS) rd_mux = bias;
    if (rd_word == W_STAT) rd_mux = {{(DATA_W-2){1'b0}}, result_valid, busy};
    if (rd_word == W_RES)  rd_mux = result;
  end

  // Final sum with ReLU on the low side and saturation to int32 max on the high side.
  assign img_x = {{DATA_W{eng_img[DATA_W-1]}}, eng_img};
  assign wt_x  = {{DATA_W{eng_wt[DATA_W-1]}}, eng_wt};
  assign sum   = acc + {{DATA_W{bias[DATA_W-1]}}, bias};
  always_comb begin
    sat = sum[DATA_W-1:0];
    if (sum[2*DATA_W-1])                  sat = '0;
    else if (|sum[2*DATA_W-2:DATA_W-1])   sat = {1'b0, {(DATA_W-1){1'b1}}};
  end

  always_ff @(posedge ACLK_0 or negedge ARESETN_0) begin
    if (!ARESETN_0) begin
      aw_rdy <= 1'b0; S00_AXI_0_bvalid <= 1'b0;
      ar_rdy <= 1'b0; rd_s1 <= 1'b0; rd_s2 <= 1'b0; rd_word <= '0;
      S00_AXI_0_rvalid <= 1'b0; S00_AXI_0_rdata <= '0;
      bias <= '0; result <= '0; state <= S_IDLE; idx <= '0;
      busy <= 1'b0; result_valid <= 1'b0; start_q <= 1'b0;
      rd_vld <= 1'b0; mul_vld <= 1'b0; prod <= '0; acc <= '0;
      a_0_tdata <= '0; a_0_tvalid <= 1'b0;
    end else begin
      // Write channel: ready pulses once per transaction, gated by the open response.
      aw_rdy <= !aw_rdy && S00_AXI_0_awvalid && S00_AXI_0_wvalid && !S00_AXI_0_bvalid;
      if (aw_rdy)                                      S00_AXI_0_bvalid <= 1'b1;
      else if (S00_AXI_0_bvalid && S00_AXI_0_bready)   S00_AXI_0_bvalid <= 1'b0;
      if (aw_rdy && wr_word == W_BIAS)
        for (int b = 0; b < DATA_W/8; b++)
          if (S00_AXI_0_wstrb[b]) bias[8*b +: 8] <= S00_AXI_0_wdata[8*b +: 8];

      // Read channel: s1 = RAM address phase, s2 = RAM data valid, then rdata.
      ar_rdy <= !ar_rdy && S00_AXI_0_arvalid && !S00_AXI_0_rvalid && !rd_s1 && !rd_s2;
      rd_s1  <= ar_rdy && S00_AXI_0_arvalid;
      rd_s2  <= rd_s1;
      if (ar_rdy && S00_AXI_0_arvalid) rd_word <= S00_AXI_0_araddr[ADDR_W-1:2];
      if (rd_s2) begin
        S00_AXI_0_rvalid <= 1'b1;
        S00_AXI_0_rdata  <= rd_mux;
      end else if (S00_AXI_0_rvalid && S00_AXI_0_rready) begin
        S00_AXI_0_rvalid <= 1'b0;
      end

      // Engine pipeline: RAM read -> multiply -> accumulate.
      start_q <= start_0;
      rd_vld  <= (state == S_RUN);
      mul_vld <= rd_vld;
      prod    <= img_x * wt_x;
      if (mul_vld) acc <= acc + prod;

      case (state)
        S_IDLE: if (start_edge && adone) begin
          state <= S_RUN; idx <= '0; acc <= '0;
          busy <= 1'b1; result_valid <= 1'b0;
        end
        S_RUN: begin
          if (idx == IDX_LAST) state <= S_DRAIN;
          else                 idx <= idx + 1'b1;
        end
        // Leave once the last RAM word has moved into the multiplier; its
        // accumulate lands on the same edge, so FINISH sees the full sum.
        S_DRAIN: if (!rd_vld) state <= S_FINISH;
        S_FINISH: begin
          result <= sat; a_0_tdata <= sat; a_0_tvalid <= 1'b1;
          result_valid <= 1'b1; state <= S_OUT;
        end
        S_OUT: if (a_0_tready) begin
          a_0_tvalid <= 1'b0; busy <= 1'b0; state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pl_nn_accel.sv
module tb_pl_nn_accel;
  logic        ACLK_0 = 1'b0;
  logic        ARESETN_0;
  logic [13:0] S00_AXI_0_awaddr, S00_AXI_0_araddr;
  logic [2:0]  S00_AXI_0_awprot, S00_AXI_0_arprot;
  logic        S00_AXI_0_awvalid, S00_AXI_0_awready, S00_AXI_0_wvalid, S00_AXI_0_wready;
  logic [31:0] S00_AXI_0_wdata, S00_AXI_0_rdata;
  logic [3:0]  S00_AXI_0_wstrb;
  logic [1:0]  S00_AXI_0_bresp, S00_AXI_0_rresp;
  logic        S00_AXI_0_bvalid, S00_AXI_0_bready, S00_AXI_0_arvalid, S00_AXI_0_arready;
  logic        S00_AXI_0_rvalid, S00_AXI_0_rready;
  logic        start_0, adone, a_0_tvalid, a_0_tready;
  logic [31:0] a_0_tdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 ACLK_0 = ~ACLK_0;

  pl_nn_accel dut (
    .ACLK_0(ACLK_0), .ARESETN_0(ARESETN_0),
    .S00_AXI_0_awaddr(S00_AXI_0_awaddr), .S00_AXI_0_awprot(S00_AXI_0_awprot),
    .S00_AXI_0_awvalid(S00_AXI_0_awvalid), .S00_AXI_0_awready(S00_AXI_0_awready),
    .S00_AXI_0_wdata(S00_AXI_0_wdata), .S00_AXI_0_wstrb(S00_AXI_0_wstrb),
    .S00_AXI_0_wvalid(S00_AXI_0_wvalid), .S00_AXI_0_wready(S00_AXI_0_wready),
    .S00_AXI_0_bresp(S00_AXI_0_bresp), .S00_AXI_0_bvalid(S00_AXI_0_bvalid),
    .S00_AXI_0_bready(S00_AXI_0_bready),
    .S00_AXI_0_araddr(S00_AXI_0_araddr), .S00_AXI_0_arprot(S00_AXI_0_arprot),
    .S00_AXI_0_arvalid(S00_AXI_0_arvalid), .S00_AXI_0_arready(S00_AXI_0_arready),
    .S00_AXI_0_rdata(S00_AXI_0_rdata), .S00_AXI_0_rresp(S00_AXI_0_rresp),
    .S00_AXI_0_rvalid(S00_AXI_0_rvalid), .S00_AXI_0_rready(S00_AXI_0_rready),
    .start_0(start_0), .adone(adone),
    .a_0_tdata(a_0_tdata), .a_0_tvalid(a_0_tvalid), .a_0_tready(a_0_tready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK_0);
    #1;
  endtask

  // hold > 0 keeps bready low for that many cycles once bvalid is seen and
  // reports in bcnt how many of those cycles bvalid stayed high.
  task automatic axi_write(input logic [13:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int hold, output int bcnt);
    logic got;
    bcnt = 0;
    S00_AXI_0_awaddr = a; S00_AXI_0_wdata = d; S00_AXI_0_wstrb = s;
    S00_AXI_0_awvalid = 1'b1; S00_AXI_0_wvalid = 1'b1; S00_AXI_0_bready = (hold == 0);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (S00_AXI_0_awready) begin got = 1'b1; break; end
    end
    if (!got) chk("aw_timeout", 32'(got), 32'd1);
    tick();
    S00_AXI_0_awvalid = 1'b0; S00_AXI_0_wvalid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (S00_AXI_0_bvalid) begin got = 1'b1; break; end
      tick();
    end
    if (!got) chk("b_timeout", 32'(got), 32'd1);
    for (int i = 0; i < hold; i++) begin
      tick();
      if (S00_AXI_0_bvalid) bcnt++;
    end
    S00_AXI_0_bready = 1'b1;
    tick();
  endtask

  task automatic axi_read(input logic [13:0] a, output logic [31:0] d, output logic [1:0] r,
                          output int lat);
    logic got;
    S00_AXI_0_araddr = a; S00_AXI_0_arvalid = 1'b1; S00_AXI_0_rready = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (S00_AXI_0_arready) begin got = 1'b1; break; end
    end
    if (!got) chk("ar_timeout", 32'(got), 32'd1);
    tick();
    S00_AXI_0_arvalid = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      if (S00_AXI_0_rvalid) break;
      tick();
      lat++;
    end
    d = S00_AXI_0_rdata; r = S00_AXI_0_rresp;
    S00_AXI_0_rready = 1'b1;
    tick();
    S00_AXI_0_rready = 1'b0;
  endtask

  // Raises start_0 for start_hold cycles with tready=1 and counts result beats.
  // lat = edges after the start-sampling edge until tvalid is seen.
  task automatic run_check(input logic adone_v, input int window,
                           output int beats, output int lat, output logic [31:0] data);
    adone = adone_v; a_0_tready = 1'b1; start_0 = 1'b1;
    beats = 0; lat = -1; data = '0;
    for (int c = 1; c <= window; c++) begin
      tick();
      if (c == 20) start_0 = 1'b0;
      if (a_0_tvalid) begin
        beats++;
        if (lat < 0) begin lat = c - 1; data = a_0_tdata; end
      end
    end
  endtask

  initial begin
    logic [31:0] d, d0;
    logic [1:0]  r;
    int lat, beats, bc, bad;

    ARESETN_0 = 1'b0;
    S00_AXI_0_awaddr = '0; S00_AXI_0_awprot = '0; S00_AXI_0_awvalid = 1'b0;
    S00_AXI_0_wdata = '0; S00_AXI_0_wstrb = '0; S00_AXI_0_wvalid = 1'b0;
    S00_AXI_0_bready = 1'b0; S00_AXI_0_araddr = '0; S00_AXI_0_arprot = '0;
    S00_AXI_0_arvalid = 1'b0; S00_AXI_0_rready = 1'b0;
    start_0 = 1'b0; adone = 1'b1; a_0_tready = 1'b1;

    // Reset state
    repeat (30) tick();
    chk("tvalid_in_reset", 32'(a_0_tvalid), 32'd0);
    ARESETN_0 = 1'b1;
    tick();
    chk("ctrl_after_reset", {26'd0, S00_AXI_0_awready, S00_AXI_0_wready, S00_AXI_0_bvalid,
                             S00_AXI_0_arready, S00_AXI_0_rvalid, a_0_tvalid}, 32'd0);
    chk("tdata_after_reset", a_0_tdata, 32'd0);
    chk("rdata_after_reset", S00_AXI_0_rdata, 32'd0);
    chk("resp_after_reset", {28'd0, S00_AXI_0_bresp, S00_AXI_0_rresp}, 32'd0);
    axi_read(14'h3004, d, r, lat);
    chk("status_reset", d, 32'd0);
    chk("read_latency", 32'(lat), 32'd2);

    // Load image[i] = weight[i] = i, bias 0
    for (int i = 0; i < 784; i++) begin
      axi_write(14'(i * 4), 32'(i), 4'hF, 0, bc);
      axi_write(14'(32'h1000 + i * 4), 32'(i), 4'hF, 0, bc);
    end
    axi_write(14'h3000, 32'd0, 4'hF, 0, bc);
    axi_write(14'h0C40, 32'h12345678, 4'hF, 0, bc);
    axi_read(14'h0014, d, r, lat);
    chk("img5_readback", d, 32'd5);
    axi_read(14'h1C3C, d, r, lat);
    chk("wt783_readback", d, 32'd783);
    axi_read(14'h0C40, d, r, lat);
    chk("img_past_end", d, 32'd0);

    // Run 1: sum of i^2, i=0..783
    run_check(1'b1, 1000, beats, lat, d);
    chk("run1_beats", 32'(beats), 32'd1);
    chk("run1_latency", 32'(lat), 32'd787);
    chk("run1_tdata", d, 32'd160322904);
    axi_read(14'h3008, d, r, lat);
    chk("run1_result_reg", d, 32'd160322904);

    // Run 2: bias -1
    axi_write(14'h3000, 32'hFFFFFFFF, 4'hF, 0, bc);
    run_check(1'b1, 1000, beats, lat, d);
    chk("run2_beats", 32'(beats), 32'd1);
    chk("run2_tdata", d, 32'd160322903);

    // Backpressure: tready low, start toggled while the result waits
    a_0_tready = 1'b0; adone = 1'b1; start_0 = 1'b1;
    for (int c = 1; c <= 1000; c++) begin
      tick();
      if (c == 5) start_0 = 1'b0;
      if (a_0_tvalid) break;
    end
    d0 = a_0_tdata;
    chk("hold_tdata", d0, 32'd160322903);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      start_0 = i[2];
      if (!a_0_tvalid || a_0_tdata !== d0) bad++;
    end
    start_0 = 1'b0;
    chk("hold_stable", 32'(bad), 32'd0);
    axi_read(14'h3004, d, r, lat);
    chk("hold_status", d, 32'd3);
    a_0_tready = 1'b1;
    tick();
    chk("tvalid_after_accept", 32'(a_0_tvalid), 32'd0);
    beats = 0;
    for (int i = 0; i < 900; i++) begin
      tick();
      if (a_0_tvalid) beats++;
    end
    chk("no_run_from_toggle", 32'(beats), 32'd0);
    axi_read(14'h3004, d, r, lat);
    chk("busy_cleared", d & 32'd1, 32'd0);

    // Byte strobes, unmapped read, held write response
    axi_write(14'h3000, 32'd0, 4'hF, 0, bc);
    axi_write(14'h3000, 32'hAABBCCDD, 4'b0011, 0, bc);
    axi_read(14'h3000, d, r, lat);
    chk("bias_wstrb", d, 32'h0000CCDD);
    axi_read(14'h2000, d, r, lat);
    chk("unmapped_rdata", d, 32'd0);
    chk("unmapped_rresp", 32'(r), 32'd0);
    axi_write(14'h3000, 32'h80000000, 4'hF, 10, bc);
    chk("bvalid_held", 32'(bc), 32'd10);

    // ReLU: weights 0, bias most negative
    for (int i = 0; i < 784; i++) axi_write(14'(32'h1000 + i * 4), 32'd0, 4'hF, 0, bc);
    run_check(1'b1, 1000, beats, lat, d);
    chk("relu_beats", 32'(beats), 32'd1);
    chk("relu_tdata", d, 32'd0);

    // Start with adone low is ignored
    run_check(1'b0, 900, beats, lat, d);
    chk("adone0_beats", 32'(beats), 32'd0);
    adone = 1'b1;

    // Reset in the middle of a run
    a_0_tready = 1'b1; start_0 = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      tick();
      if (c == 10) start_0 = 1'b0;
    end
    ARESETN_0 = 1'b0;
    repeat (5) tick();
    ARESETN_0 = 1'b1;
    beats = 0;
    for (int i = 0; i < 900; i++) begin
      tick();
      if (a_0_tvalid) beats++;
    end
    chk("midrun_reset_beats", 32'(beats), 32'd0);
    axi_read(14'h3004, d, r, lat);
    chk("status_after_reset", d, 32'd0);

    // Reset while a result is waiting: tvalid drops without a clock edge
    a_0_tready = 1'b0; start_0 = 1'b1;
    for (int c = 1; c <= 1000; c++) begin
      tick();
      if (c == 5) start_0 = 1'b0;
      if (a_0_tvalid) break;
    end
    chk("out_tvalid_before_reset", 32'(a_0_tvalid), 32'd1);
    ARESETN_0 = 1'b0;
    #1;
    chk("tvalid_async_drop", 32'(a_0_tvalid), 32'd0);
    repeat (3) tick();
    ARESETN_0 = 1'b1;
    a_0_tready = 1'b1;
    axi_read(14'h3004, d, r, lat);
    chk("status_after_async_reset", d, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pl_nn_accel.md
Name: pl_nn_accel

Overview:
- Single-perceptron inference engine for the programmable-logic neural-network path.
- Host loads a 784-pixel image and 784 weights, plus a bias, over an AXI4-Lite slave.
- On a start pulse it computes the dot product plus bias, applies ReLU, and emits one 32-bit result on an AXI-Stream master.

Parameters:
- N_INPUTS, 784, number of pixel/weight words.
- ADDR_W, 14, AXI4-Lite address width (byte addressing).
- DATA_W, 32, AXI data and stream width.

Ports:
- ACLK_0  in  1  clock; all logic on rising edge.
- ARESETN_0  in  1  reset, asynchronous active-low.
- S00_AXI_0_awaddr  in  14  write address.
- S00_AXI_0_awprot  in  3  ignored.
- S00_AXI_0_awvalid  in  1; S00_AXI_0_awready  out  1.
- S00_AXI_0_wdata  in  32; S00_AXI_0_wstrb  in  4 (byte enables).
- S00_AXI_0_wvalid  in  1; S00_AXI_0_wready  out  1.
- S00_AXI_0_bresp  out  2; S00_AXI_0_bvalid  out  1; S00_AXI_0_bready  in  1.
- S00_AXI_0_araddr  in  14; S00_AXI_0_arprot  in  3 (ignored).
- S00_AXI_0_arvalid  in  1; S00_AXI_0_arready  out  1.
- S00_AXI_0_rdata  out  32; S00_AXI_0_rresp  out  2; S00_AXI_0_rvalid  out  1; S00_AXI_0_rready  in  1.
- start_0  in  1  compute request; rising edge triggers a run.
- adone  in  1  downstream-idle enable; a start edge is accepted only while adone=1.
- a_0_tdata  out  32  result.
- a_0_tvalid  out  1; a_0_tready  in  1.

Behaviour:
- Clocking and reset: one clock, ACLK_0. Reset is asynchronous and active-low on ARESETN_0.
- Reset values:
  - All ready/valid outputs 0; bresp = rresp = 0; rdata = 0; a_0_tdata = 0.
  - FSM = IDLE; bias = 0; result register = 0; start edge detector cleared.
  - Image and weight RAM contents are not cleared.
- Address map (word-aligned; addr[1:0] ignored):
  - 0x0000-0x0C3C: image RAM, 784 words.
  - 0x1000-0x1C3C: weight RAM, 784 words.
  - 0x3000: bias (RW).
  - 0x3004: status (RO): bit0 busy, bit1 result_valid.
  - 0x3008: last result (RO).
  - Unmapped writes are discarded; unmapped reads return 0. bresp/rresp are always OKAY (0).
- AXI write:
  - awready and wready pulse together for 1 cycle when awvalid && wvalid && !bvalid.
  - The write is performed in that cycle, honouring wstrb per byte.
  - bvalid rises the next cycle and holds until bready; the next write is accepted only after the bvalid/bready handshake.
  - One outstanding write at a time.
- AXI read:
  - arready pulses for 1 cycle when arvalid && !rvalid && no read pending.
  - rvalid and rdata appear exactly 2 cycles after the AR handshake (synchronous RAM read).
  - rvalid holds with stable rdata until rready.
- RAMs are dual-port (AXI port plus engine read port). AXI writes during BUSY are performed; the result of that run is then unspecified.
- Start detection: start_edge = start_0 && !start_q, where start_q is start_0 registered. A held start_0 triggers exactly one run.
- FSM:
  - IDLE → RUN on start_edge && adone: acc cleared to 0, index = 0, busy = 1. Otherwise remain in IDLE.
  - RUN: each cycle read image[index] and weight[index]. One cycle later, acc += signed(img) * signed(wt), using a 64-bit product and a 64-bit signed accumulator (wraps on overflow). After index 783 is issued, drain the pipeline.
  - FINISH: sum = acc + sign-extended bias. result = 0 if sum < 0; 0x7FFFFFFF if sum > 0x7FFFFFFF; otherwise sum[31:0]. Load a_0_tdata; a_0_tvalid = 1; result_valid = 1; go to OUT.
  - OUT: hold tvalid and tdata stable until a_0_tready = 1, then tvalid = 0, busy = 0, go to IDLE.
- Latency: a_0_tvalid rises exactly 787 cycles after the cycle start_edge is sampled.
- Start edges in RUN, FINISH or OUT are ignored.
- Reset mid-run: immediate return to IDLE; tvalid drops asynchronously; no partial result is emitted.

Test Plan:
- Reset hold 30 cycles, then release → all AXI ready/valid outputs and a_0_tvalid are 0; a read of 0x3004 returns 0.
- Write image[i] = i and weight[i] = i for i = 0..783 (0x0000 and 0x1000 bases), bias = 0. Raise start_0 for 20 cycles with adone = 1, tready = 1 → exactly one tvalid beat, tdata = 160322904, 787 cycles after the edge.
- Same data, bias = 0xFFFFFFFF (−1) → tdata = 160322903. Then bias = 0x80000000 with all weights 0 → tdata = 0 (ReLU).
- Write 0xAABBCCDD to 0x3000 with wstrb = 0011, then read → 0x0000CCDD. Read unmapped 0x2000 → 0 with rresp = OKAY. bvalid stays held while bready = 0 for 10 cycles.
- Hold tready = 0 for 50 cycles after tvalid → tdata stable, status = 0x3. Toggle start_0 during this window → no new run.
- Start edge with adone = 0 → no run. Deassert ARESETN_0 mid-run → tvalid stays 0 and status reads 0 after reset release.
